// File: rtl/laplace9_approx_2.sv
// ---------------------------------------------------------------------------
// laplace9_approx_2
//   Two-stage pipelined 5-point (cross) Laplacian edge filter, approximate
//   variant: s = sat(4e - b - d - f - h), computed after clearing the
//   APPROX_BITS LSBs of every input pixel.
//
//   Stage 1 : truncate operands, form 4e' and b'+d'+f'+h' (captured only
//             when in_valid is high; v1 tracks in_valid every edge).
//   Stage 2 : signed difference, saturate to [0, 2**PIX_W-1], register s.
//
//   Optional build macro LAPLACE_ABS_EN: stage 2 outputs min(|diff|, max)
//   instead of clamping negative responses to zero.
//
// Parameters
//   APPROX_BITS : LSBs cleared on every input pixel (0..4, 0 = exact)
//   PIX_W       : pixel width of inputs and output
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : b, d, e, f, h carry a valid window this cycle
//   b, d, f, h : up, left, right, down neighbour pixels
//   e          : centre pixel
//   out_valid  : s holds a valid result this cycle
//   s          : filtered pixel (holds its value while out_valid is low)
// ---------------------------------------------------------------------------
module laplace9_approx_2 #(
  parameter int APPROX_BITS = 2,
  parameter int PIX_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] b,
  input  logic [PIX_W-1:0] d,
  input  logic [PIX_W-1:0] e,
  input  logic [PIX_W-1:0] f,
  input  logic [PIX_W-1:0] h,
  output logic             out_valid,
  output logic [PIX_W-1:0] s
);

  localparam int SUM_W  = PIX_W + 2;
  localparam int DIFF_W = PIX_W + 3;

  // Keep-mask for the approximation: low APPROX_BITS bits are zero.
  localparam logic [PIX_W-1:0] KEEP_MASK = {PIX_W{1'b1}} << APPROX_BITS;

  // Largest representable output value, as a signed difference-width number.
  localparam logic signed [DIFF_W-1:0] SAT_MAX =
    $signed({3'b000, {PIX_W{1'b1}}});

  // -------------------------------------------------------------------------
  // Stage 1: operand truncation and partial sums
  // -------------------------------------------------------------------------
  logic [PIX_W-1:0] bt, dt, et, ft, ht;
  logic [SUM_W-1:0] e4_d, nsum_d;

  assign bt = b & KEEP_MASK;
  assign dt = d & KEEP_MASK;
  assign et = e & KEEP_MASK;
  assign ft = f & KEEP_MASK;
  assign ht = h & KEEP_MASK;

  assign e4_d   = {et, 2'b00};
  // Four PIX_W-bit terms fit in PIX_W+2 bits, so this sum cannot overflow.
  assign nsum_d = SUM_W'(bt) + SUM_W'(dt) + SUM_W'(ft) + SUM_W'(ht);

  logic [SUM_W-1:0] e4_q, nsum_q;
  logic             v1_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e4_q   <= '0;
      nsum_q <= '0;
      v1_q   <= 1'b0;
    end else begin
      v1_q <= in_valid;
      // Data registers hold while no window arrives; v1 alone marks validity.
      if (in_valid) begin
        e4_q   <= e4_d;
        nsum_q <= nsum_d;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: signed difference and saturation
  // -------------------------------------------------------------------------
  logic signed [DIFF_W-1:0] diff;
  logic signed [DIFF_W-1:0] mag;
  logic [PIX_W-1:0]         sat_d;

  // Zero-extend both operands by one bit so the subtraction is signed-safe.
  assign diff = $signed({1'b0, e4_q}) - $signed({1'b0, nsum_q});

  // NOTE: every output of this block gets a default first so no path through
  // it leaves a variable unassigned, which would infer a latch.
  always_comb begin
    sat_d = '0;
    mag   = diff;
`ifdef LAPLACE_ABS_EN
    // Negative responses become positive edge magnitude. |diff| never
    // exceeds 4*(2**PIX_W-1), which is representable in DIFF_W signed bits.
    if (diff < 0) mag = -diff;
`endif
    if (mag < 0)            sat_d = '0;
    else if (mag > SAT_MAX) sat_d = '1;
    else                    sat_d = mag[PIX_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s         <= '0;
    end else begin
      out_valid <= v1_q;
      if (v1_q) s <= sat_d;
    end
  end

endmodule

// File: tb/tb_laplace9_approx_2.sv
// ---------------------------------------------------------------------------
// tb_laplace9_approx_2
//   Self-checking bench for laplace9_approx_2. Windows are driven on the
//   falling edge; the expected result and the cycle it is due on are pushed
//   to a scoreboard queue, and a falling-edge monitor pops and compares when
//   out_valid is seen. Reset and mid-stream reset are checked by hand.
// ---------------------------------------------------------------------------
module tb_laplace9_approx_2;

  localparam int A = 2;  // APPROX_BITS of the instance under test

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] b = '0, d = '0, e = '0, f = '0, h = '0;
  logic       out_valid;
  logic [7:0] s;

  laplace9_approx_2 #(.APPROX_BITS(A), .PIX_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .b         (b),
    .d         (d),
    .e         (e),
    .f         (f),
    .h         (h),
    .out_valid (out_valid),
    .s         (s)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [7:0] exp;
    int         due;
    string      name;
  } sb_t;

  sb_t q[$];

  typedef struct {
    logic [7:0] b, d, e, f, h;
    logic [7:0] exp;
    string      name;
  } vec_t;

  task automatic check(input string nm, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Independent reference: integer arithmetic on shift-truncated pixels.
  function automatic int ref_filter(input int bb, dd, ee, ff, hh);
    int dv;
    dv = 4 * ((ee >> A) << A)
       - ((bb >> A) << A) - ((dd >> A) << A)
       - ((ff >> A) << A) - ((hh >> A) << A);
`ifdef LAPLACE_ABS_EN
    if (dv < 0) dv = -dv;
`endif
    if (dv < 0)   return 0;
    if (dv > 255) return 255;
    return dv;
  endfunction

  // Drive one cycle of stimulus on the falling edge; a valid window's result
  // is due at the falling edge two rising edges later.
  task automatic drive(input logic v, input logic [7:0] bb, dd, ee, ff, hh,
                       input logic [7:0] ex, input string nm);
    sb_t it;
    @(negedge clk);
    in_valid = v;
    b = bb; d = dd; e = ee; f = ff; h = hh;
    if (v) begin
      it.exp  = ex;
      it.due  = cyc + 2;
      it.name = nm;
      q.push_back(it);
    end
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) check({nm, "_timeout"}, q.size(), 0);
    @(negedge clk);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    sb_t it;
    if (mon_en) begin
      if (out_valid) begin
        if (q.size() == 0) check("unexpected_out_valid", 1, 0);
        else begin
          it = q.pop_front();
          check({it.name, "_latency"}, cyc, it.due);
          check(it.name, int'(s), int'(it.exp));
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        it = q.pop_front();
        check({it.name, "_missing"}, 0, 1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  vec_t tbl[9];

  initial begin
    int rb, rd, re, rf, rh;

    tbl[0] = '{8'd0,   8'd0,   8'd255, 8'd0,   8'd0,   8'd255, "sat_high"};
`ifdef LAPLACE_ABS_EN
    tbl[1] = '{8'd200, 8'd200, 8'd0,   8'd200, 8'd200, 8'd255, "sat_low"};
`else
    tbl[1] = '{8'd200, 8'd200, 8'd0,   8'd200, 8'd200, 8'd0,   "sat_low"};
`endif
    tbl[2] = '{8'd10,  8'd10,  8'd50,  8'd10,  8'd10,  8'd160, "trunc_50_10"};
    tbl[3] = '{8'd3,   8'd3,   8'd7,   8'd3,   8'd3,   8'd16,  "trunc_7_3"};
    tbl[4] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   "all_zero"};
    tbl[5] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0,   "all_max"};
    tbl[6] = '{8'd20,  8'd0,   8'd40,  8'd0,   8'd0,   8'd140, "one_nbr"};
    tbl[7] = '{8'd8,   8'd16,  8'd64,  8'd32,  8'd4,   8'd196, "mixed_nbr"};
    tbl[8] = '{8'd0,   8'd0,   8'd64,  8'd0,   8'd1,   8'd255, "edge_256"};

    // --- reset held with live, valid-looking inputs ---
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      b = 8'($urandom); d = 8'($urandom); e = 8'($urandom);
      f = 8'($urandom); h = 8'($urandom);
      #1;
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_s", int'(s), 0);
    end

    // --- release, first window after reset ---
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    in_valid = 1'b1;
    b = 8'd100; d = 8'd100; e = 8'd100; f = 8'd100; h = 8'd100;
    q.push_back('{8'd0, cyc + 2, "reset_first"});
    drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, "idle");
    drain("reset_first");

    // --- table, back-to-back ---
    for (int i = 0; i < 9; i++)
      drive(1'b1, tbl[i].b, tbl[i].d, tbl[i].e, tbl[i].f, tbl[i].h,
            tbl[i].exp, tbl[i].name);
    drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, "idle");
    drain("table");

    // --- random windows with gaps ---
    for (int i = 0; i < 12; i++) begin
      rb = int'($urandom_range(255)); rd = int'($urandom_range(255));
      re = int'($urandom_range(255)); rf = int'($urandom_range(255));
      rh = int'($urandom_range(255));
      drive(1'b1, 8'(rb), 8'(rd), 8'(re), 8'(rf), 8'(rh),
            8'(ref_filter(rb, rd, re, rf, rh)), "random");
      if ($urandom_range(2) == 0)
        drive(1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom), 8'd0, "gap");
    end
    drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, "idle");
    drain("random");

    // --- streaming: four back-to-back windows, then idle ---
    drive(1'b1, 8'd60, 8'd60, 8'd64, 8'd60, 8'd60, 8'd16,  "stream0");
    drive(1'b1, 8'd0,  8'd0,  8'd64, 8'd0,  8'd0,  8'd255, "stream1");
    drive(1'b1, 8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd0,   "stream2");
    drive(1'b1, 8'd16, 8'd16, 8'd32, 8'd16, 8'd16, 8'd64,  "stream3");
    drive(1'b0, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd0,   "idle");
    drain("stream");
    check("stream_drop_out_valid", int'(out_valid), 0);
    check("stream_hold_s", int'(s), 64);

    // --- mid-stream reset with two windows in flight ---
    drive(1'b1, 8'd10, 8'd10, 8'd50, 8'd10, 8'd10, 8'd160, "inflight0");
    drive(1'b1, 8'd16, 8'd16, 8'd32, 8'd16, 8'd16, 8'd64,  "inflight1");
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("midreset_out_valid", int'(out_valid), 0);
    check("midreset_s", int'(s), 0);
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_reset_no_stale", int'(out_valid), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
